// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the rv_core single-cycle RV32I-subset core.
//   - opcode, funct3 and funct7 encodings of the supported instructions
//   - alu_op_t: operations the ALU can perform
//   - ctrl_t: per-instruction control bundle produced by the decoder
//   - sext12: sign-extension helper for 12-bit immediates
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SLT = 3'd5
    } alu_op_t;

    typedef struct packed {
        logic    reg_we;      // write the ALU/load result to rd
        logic    mem_we;      // store rs2 to data RAM
        logic    alu_src_imm; // ALU operand B is the immediate instead of rs2
        logic    mem_to_reg;  // rd takes the RAM read data (LW)
        logic    branch;      // BEQ: redirect pc when rs1 == rs2
        alu_op_t alu_op;
    } ctrl_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv_core_alu.sv
// rv_core_alu: 32-bit integer ALU, modulo 2^32 arithmetic.
//   op_i      operation select (alu_op_t)
//   a_i, b_i  operands
//   y_o       result; SLT yields 1 or 0 from a signed compare
module rv_core_alu
    import rv_pkg::*;
(
    input  alu_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ADD:     y_o = a_i + b_i;
            SUB:     y_o = a_i - b_i;
            AND:     y_o = a_i & b_i;
            OR:      y_o = a_i | b_i;
            XOR:     y_o = a_i ^ b_i;
            SLT:     y_o = {31'd0, $signed(a_i) < $signed(b_i)};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_core_decoder.sv
// rv_core_decoder: combinational instruction decode and immediate generation.
//   inst_i                 instruction word
//   ctrl_o                 control bundle (all zero for unsupported encodings)
//   rs1_o, rs2_o, rd_o     register fields
//   imm_o                  sign-extended immediate chosen for the format
// Any encoding not explicitly matched leaves ctrl_o at zero, which makes the
// core treat it as a NOP (no writes, pc+4).
module rv_core_decoder
    import rv_pkg::*;
(
    input  logic [31:0] inst_i,
    output ctrl_t       ctrl_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;

    assign opcode = inst_i[6:0];
    assign rd_o   = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1_o  = inst_i[19:15];
    assign rs2_o  = inst_i[24:20];
    assign funct7 = inst_i[31:25];

    assign imm_i = sext12(inst_i[31:20]);
    assign imm_s = sext12({inst_i[31:25], inst_i[11:7]});
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ADD;
        imm_o         = '0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = ADD; end
                        F3_XOR:     begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = XOR; end
                        F3_OR:      begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = OR;  end
                        F3_AND:     begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = AND; end
                        F3_SLT:     begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = SLT; end
                        default: ;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    ctrl_o.reg_we = 1'b1;
                    ctrl_o.alu_op = SUB;
                end
            end
            OP_IMM: begin
                imm_o = imm_i;
                case (funct3)
                    F3_ADD_SUB: begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = ADD; end
                    F3_XOR:     begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = XOR; end
                    F3_OR:      begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = OR;  end
                    F3_AND:     begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = AND; end
                    F3_SLT:     begin ctrl_o.reg_we = 1'b1; ctrl_o.alu_op = SLT; end
                    default: ;
                endcase
                ctrl_o.alu_src_imm = ctrl_o.reg_we;
            end
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    imm_o              = imm_i;
                    ctrl_o.reg_we      = 1'b1;
                    ctrl_o.mem_to_reg  = 1'b1;
                    ctrl_o.alu_src_imm = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_SW) begin
                    imm_o              = imm_s;
                    ctrl_o.mem_we      = 1'b1;
                    ctrl_o.alu_src_imm = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    imm_o         = imm_b;
                    ctrl_o.branch = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_core_dmem.sv
// rv_core_dmem: word-addressed data RAM, combinational read, write on clk.
//   clk_i     clock
//   we_i      write enable
//   addr_i    word index (byte offset and upper address bits already dropped)
//   wdata_i   store data
//   rdata_o   read data at addr_i
// Contents are deliberately not reset.
module rv_core_dmem #(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] ram_q [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            ram_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = ram_q[addr_i];

endmodule

// File: rtl/rv_core_imem.sv
// rv_core_imem: instruction ROM with combinational read.
//   addr_i [AW-1:0]  word index (pc with byte offset and upper bits dropped)
//   data_o [31:0]    instruction word at addr_i
// rom_data has no driver inside the design; its contents are loaded from
// outside through the hierarchy.
module rv_core_imem #(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   data_o
);

    logic [31:0] rom_data [WORDS];

    assign data_o = rom_data[addr_i];

endmodule

// File: rtl/rv_core_regfile.sv
// rv_core_regfile: 32 x 32-bit integer register file.
//   clk_i, rst_i           clock, asynchronous active-high reset (clears all)
//   rs1_addr_i/rs2_addr_i  combinational read addresses
//   rs1_data_o/rs2_data_o  read data, x0 always reads as zero
//   we_i, rd_addr_i, rd_data_i  single write port, writes to x0 dropped
module rv_core_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        we_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (rd_addr_i != 5'd0)) begin
            regs_q[rd_addr_i] <= rd_data_i;
        end
    end

    // x0 is forced on the read side as well, so it reads zero regardless
    // of what the storage element holds.
    assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/rv_core.sv
// rv_core: single-cycle RV32I-subset core (ADD/SUB/XOR/OR/AND/SLT, the
// immediate forms, LW, SW, BEQ). One instruction is fetched, executed and
// committed per rising clock edge; register write, RAM write and pc update
// all happen on that same edge.
//   clk    clock, rising edge
//   reset  asynchronous, active-high: pc and registers cleared, RAM kept
// Parameters: IMEM_WORDS (ROM depth), DMEM_WORDS (RAM depth), in 32-bit words.
module rv_core
    import rv_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic clk,
    input  logic reset
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst;
    ctrl_t       ctrl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] ram_rdata;
    logic [31:0] wb_data;
    logic        br_taken;

    // The ROM index is the pc with the byte offset and upper bits dropped,
    // so a pc running past the end simply wraps through the ROM.
    rv_core_imem #(.WORDS(IMEM_WORDS)) inst_mem (
        .addr_i (pc_q[IMEM_AW+1:2]),
        .data_o (inst)
    );

    rv_core_decoder u_dec (
        .inst_i (inst),
        .ctrl_o (ctrl),
        .rs1_o  (rs1_addr),
        .rs2_o  (rs2_addr),
        .rd_o   (rd_addr),
        .imm_o  (imm)
    );

    rv_core_regfile u_regfile (
        .clk_i      (clk),
        .rst_i      (reset),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_data_o (rs1_val),
        .rs2_data_o (rs2_val),
        .we_i       (ctrl.reg_we),
        .rd_addr_i  (rd_addr),
        .rd_data_i  (wb_data)
    );

    assign alu_b = ctrl.alu_src_imm ? imm : rs2_val;

    rv_core_alu u_alu (
        .op_i (ctrl.alu_op),
        .a_i  (rs1_val),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    // The RAM has no reset of its own, so stores are blocked here while
    // reset is high; otherwise an aborted SW could still commit.
    rv_core_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
        .clk_i   (clk),
        .we_i    (ctrl.mem_we & ~reset),
        .addr_i  (alu_y[DMEM_AW+1:2]),
        .wdata_i (rs2_val),
        .rdata_o (ram_rdata)
    );

    assign wb_data  = ctrl.mem_to_reg ? ram_rdata : alu_y;
    assign br_taken = ctrl.branch && (rs1_val == rs2_val);
    assign pc_d     = br_taken ? (pc_q + imm) : (pc_q + 32'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_rv_core.sv
// tb_rv_core: self-checking bench for rv_core. A directed program covers the
// listed instruction behaviours and a mid-run reset; random programs are
// then checked cycle by cycle against an instruction-level model.
module tb_rv_core;

    localparam int IMEM_WORDS = 64;
    localparam int DMEM_WORDS = 64;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];

    // instruction-level reference state
    logic [31:0] rom_img [IMEM_WORDS];
    logic [31:0] m_regs  [32];
    logic [31:0] m_ram   [DMEM_WORDS];
    logic [31:0] m_pc;

    rv_core #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) cpu (
        .clk   (clk),
        .reset (reset)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // ---------------- reference model ----------------
    function automatic void m_write(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) m_regs[rd] = v;
    endfunction

    function automatic void model_reset();
        m_pc = 32'd0;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    endfunction

    function automatic void model_step();
        logic [31:0] inst, a, b, immi, imms, immb, addr, nxt;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        inst = rom_img[m_pc[7:2]];
        opc  = inst[6:0];
        rd   = inst[11:7];
        f3   = inst[14:12];
        f7   = inst[31:25];
        a    = m_regs[inst[19:15]];
        b    = m_regs[inst[24:20]];
        immi = {{20{inst[31]}}, inst[31:20]};
        imms = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        immb = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        nxt  = m_pc + 32'd4;
        if (opc == 7'h33 && f7 == 7'h00) begin
            case (f3)
                3'd0: m_write(rd, a + b);
                3'd4: m_write(rd, a ^ b);
                3'd6: m_write(rd, a | b);
                3'd7: m_write(rd, a & b);
                3'd2: m_write(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
        end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            m_write(rd, a - b);
        end else if (opc == 7'h13) begin
            case (f3)
                3'd0: m_write(rd, a + immi);
                3'd4: m_write(rd, a ^ immi);
                3'd6: m_write(rd, a | immi);
                3'd7: m_write(rd, a & immi);
                3'd2: m_write(rd, ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0);
                default: ;
            endcase
        end else if (opc == 7'h03 && f3 == 3'd2) begin
            addr = a + immi;
            m_write(rd, m_ram[addr[7:2]]);
        end else if (opc == 7'h23 && f3 == 3'd2) begin
            addr = a + imms;
            m_ram[addr[7:2]] = b;
        end else if (opc == 7'h63 && f3 == 3'd0 && a == b) begin
            nxt = m_pc + immb;
        end
        m_pc = nxt;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_rom(input logic [31:0] img [IMEM_WORDS]);
        for (int i = 0; i < IMEM_WORDS; i++) begin
            rom_img[i] = img[i];
            cpu.inst_mem.rom_data[i] = img[i];
        end
    endtask

    // Holds reset across one edge (nothing may change), then releases at a
    // falling edge so the next rising edge executes ROM[0].
    task automatic apply_reset(input logic [31:0] img [IMEM_WORDS]);
        @(negedge clk);
        reset = 1'b1;
        load_rom(img);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_pc", cpu.pc_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advances n edges; the model predicts pc and the whole register file.
    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            model_step();
            exp_q.push_back(m_pc);
            for (int r = 0; r < 32; r++) exp_q.push_back(m_regs[r]);
            @(posedge clk);
            #1;
            check("pc", cpu.pc_q, exp_q.pop_front());
            for (int r = 0; r < 32; r++)
                check($sformatf("x%0d", r), cpu.u_regfile.regs_q[r], exp_q.pop_front());
        end
    endtask

    task automatic check_ram();
        for (int i = 0; i < DMEM_WORDS; i++)
            check($sformatf("ram%0d", i), cpu.u_dmem.ram_q[i], m_ram[i]);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm12;
        logic [12:0] imm13;
        int          k;
        int          off;
        rd    = 5'($urandom_range(0, 7));
        rs1   = 5'($urandom_range(0, 7));
        rs2   = 5'($urandom_range(0, 7));
        imm12 = 12'($urandom);
        k     = $urandom_range(0, 11);
        if (k <= 2) begin
            case ($urandom_range(0, 6))
                0: return enc_r(7'h00, rs2, rs1, 3'd0, rd);
                1: return enc_r(7'h20, rs2, rs1, 3'd0, rd);
                2: return enc_r(7'h00, rs2, rs1, 3'd4, rd);
                3: return enc_r(7'h00, rs2, rs1, 3'd6, rd);
                4: return enc_r(7'h00, rs2, rs1, 3'd7, rd);
                5: return enc_r(7'h00, rs2, rs1, 3'd2, rd);
                default: return enc_r(7'h01, rs2, rs1, 3'($urandom), rd);
            endcase
        end else if (k <= 5) begin
            case ($urandom_range(0, 5))
                0: f3 = 3'd0;
                1: f3 = 3'd4;
                2: f3 = 3'd6;
                3: f3 = 3'd7;
                4: f3 = 3'd2;
                default: f3 = 3'd1;
            endcase
            return enc_i(imm12, rs1, f3, rd, 7'h13);
        end else if (k == 6) begin
            return enc_i(imm12, rs1, 3'd2, rd, 7'h03);
        end else if (k == 7) begin
            return enc_s(imm12, rs2, rs1);
        end else if (k <= 9) begin
            off = ($urandom_range(0, 8) - 4) * 4;
            if (off == 0) off = 8;
            imm13 = 13'(off);
            return enc_b(imm13, rs2, rs1, 3'd0);
        end else if (k == 10) begin
            return $urandom;
        end
        return enc_i(imm12, rs1, 3'd1, rd, 7'h03);
    endfunction

    // ---------------- main sequence ----------------
    logic [31:0] img [IMEM_WORDS];

    initial begin
        reset = 1'b1;
        for (int i = 0; i < DMEM_WORDS; i++) m_ram[i] = 32'd0;

        // Clear the whole RAM with SW x0 so the model knows every word.
        for (int i = 0; i < IMEM_WORDS; i++) img[i] = enc_s(12'(i * 4), 5'd0, 5'd0);
        apply_reset(img);
        for (int r = 1; r < 32; r++)
            check($sformatf("rst_x%0d", r), cpu.u_regfile.regs_q[r], 32'd0);
        step(IMEM_WORDS);
        check_ram();

        // Directed program.
        for (int i = 0; i < IMEM_WORDS; i++) img[i] = 32'd0;
        img[0]  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);   // ADDI x1,x0,5
        img[1]  = enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13);   // ADDI x2,x0,7
        img[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);     // ADD  x3
        img[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);     // SUB  x4
        img[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd5);     // OR   x5
        img[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd6);     // AND  x6
        img[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd7);     // SLT  x7
        img[7]  = enc_s(12'd0, 5'd2, 5'd1);                 // SW x2,0(x1)
        img[8]  = enc_i(12'd0, 5'd1, 3'd2, 5'd8, 7'h03);    // LW x8,0(x1)
        img[9]  = enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13);    // ADDI x0,x0,9
        img[10] = enc_i(12'd0, 5'd4, 3'd2, 5'd9, 7'h13);    // SLTI x9,x4,0
        img[11] = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd10);    // XOR  x10
        img[12] = 32'h0000_0000;                            // undefined
        img[13] = enc_b(13'd8, 5'd2, 5'd1, 3'd0);           // BEQ x1,x2,+8
        img[14] = enc_b(13'h1FF8, 5'd1, 5'd1, 3'd0);        // BEQ x1,x1,-8
        apply_reset(img);
        step(2);
        check("addi_x1", cpu.u_regfile.regs_q[1], 32'd5);
        check("addi_x2", cpu.u_regfile.regs_q[2], 32'd7);
        check("pc_after2", cpu.pc_q, 32'd8);
        step(1); check("add", cpu.u_regfile.regs_q[3], 32'd12);
        step(1); check("sub", cpu.u_regfile.regs_q[4], 32'hFFFF_FFFE);
        step(1); check("or", cpu.u_regfile.regs_q[5], 32'd7);
        step(1); check("and", cpu.u_regfile.regs_q[6], 32'd5);
        step(1); check("slt", cpu.u_regfile.regs_q[7], 32'd1);
        step(1); check("sw_ram1", cpu.u_dmem.ram_q[1], 32'd7);
        step(1); check("lw", cpu.u_regfile.regs_q[8], 32'd7);
        step(1); check("x0_zero", cpu.u_regfile.regs_q[0], 32'd0);
        step(1); check("slti_neg", cpu.u_regfile.regs_q[9], 32'd1);
        step(1); check("xor", cpu.u_regfile.regs_q[10], 32'd2);
        step(1); check("nop_pc", cpu.pc_q, 32'd52);
        step(1); check("beq_nt_pc", cpu.pc_q, 32'd56);
        step(1); check("beq_t_pc", cpu.pc_q, 32'd48);
        step(6);
        check_ram();

        // Mid-run reset: abort after x1 has been written.
        apply_reset(img);
        step(2);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_pc", cpu.pc_q, 32'd0);
        check("midrst_x1", cpu.u_regfile.regs_q[1], 32'd0);
        @(posedge clk);
        #1;
        check("hold_pc", cpu.pc_q, 32'd0);
        check("hold_x1", cpu.u_regfile.regs_q[1], 32'd0);
        check("hold_ram1", cpu.u_dmem.ram_q[1], 32'd7);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        step(2);
        check("rerun_x1", cpu.u_regfile.regs_q[1], 32'd5);
        check("rerun_pc", cpu.pc_q, 32'd8);

        // Random programs; RAM contents carry over between them.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < IMEM_WORDS; i++) img[i] = rand_inst();
            apply_reset(img);
            step(120);
            check_ram();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
